// File: rtl/parity_arbiter.sv
// Round-robin sharing of one registered even-parity engine among NREQ requesters.
// Optional result cross-check (chk_err output) enabled by defining PARITY_ARB_CHECK_EN.
module parity_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 5,
  parameter int SETUP_CYC = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW:0]       rsp_data,
  output logic              busy,
  output logic [DW-1:0]     eng_data,
  output logic              eng_start,
  input  logic [DW:0]       eng_result
`ifdef PARITY_ARB_CHECK_EN
  ,
  output logic              chk_err
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(SETUP_CYC + 1) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, START, CAPT} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [DW-1:0]     data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW:0]       rsp_data_q, rsp_data_d;
  logic              chk_q, chk_d;
  logic [PW-1:0]     win;
  logic              arb_go;

  // First set request strictly after the pointer, wrapping around.
  function automatic logic [PW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                input logic [PW-1:0]   p);
    logic [PW-1:0] w;
    logic          found;
    int            idx;
    w     = p;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        w     = PW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic parity_of(input logic [DW-1:0] d);
    return ^d;
  endfunction

  assign win = pick_winner(req, ptr_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    chk_d       = 1'b0;
    arb_go      = 1'b0;
    case (state_q)
      IDLE: arb_go = |req;
      // First SETUP cycle lets the engine's parity register load; then SETUP_CYC hold cycles.
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC)) state_d = START;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      START: state_d = CAPT;
      CAPT: begin
        rsp_data_d           = eng_result;
        rsp_valid_d[owner_q] = 1'b1;
        chk_d                = (eng_result != {data_q, parity_of(data_q)});
        state_d              = IDLE;
        // Arbitrate on the same edge as the response so back-to-back grants lose no cycle.
        arb_go               = |req;
      end
      default: state_d = IDLE;
    endcase
    if (arb_go) begin
      gnt_d[win] = 1'b1;
      owner_d    = win;
      ptr_d      = win;
      data_d     = req_data[int'(win)*DW +: DW];
      cnt_d      = '0;
      state_d    = SETUP;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(NREQ - 1);
      owner_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      chk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      chk_q       <= chk_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign eng_data  = data_q;
  assign eng_start = (state_q == START);

`ifdef PARITY_ARB_CHECK_EN
  assign chk_err = chk_q;
`else
  logic unused_chk;
  assign unused_chk = chk_q;
`endif

endmodule

// File: tb/tb_parity_arbiter.sv
// Scoreboard bench for parity_arbiter with a registered parity engine model.
module tb_parity_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 5;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [DW:0]       rsp_data;
  logic              busy, eng_start;
  logic [DW-1:0]     eng_data;
  logic [DW:0]       eng_res;
  logic              par_q;
  logic              flip = 1'b0;
  logic              chk_err_w;

  parity_arbiter #(.NREQ(NREQ), .DW(DW), .SETUP_CYC(1)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .eng_data(eng_data), .eng_start(eng_start), .eng_result(eng_res)
`ifdef PARITY_ARB_CHECK_EN
    , .chk_err(chk_err_w)
`endif
  );
`ifndef PARITY_ARB_CHECK_EN
  assign chk_err_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // Engine: parity registered every cycle, result captured on start.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q   <= 1'b0;
      eng_res <= '0;
    end else begin
      par_q <= ^eng_data;
      if (eng_start) eng_res <= {eng_data, par_q ^ flip};
    end
  end

  typedef struct {logic [NREQ-1:0] v; logic [DW:0] d; int cyc; logic chk;} ev_t;
  typedef struct {logic [NREQ-1:0] g; logic [DW:0] d; logic chk;} exp_t;
  ev_t  gq[$];
  ev_t  rq[$];
  int   sq[$];
  exp_t eq[$];
  int   cyc = 0;
  int   stray_chk = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (gnt != '0) gq.push_back('{gnt, '0, cyc, 1'b0});
    if (rsp_valid != '0) rq.push_back('{rsp_valid, rsp_data, cyc, chk_err_w});
    if (eng_start) sq.push_back(cyc);
    if (chk_err_w && rsp_valid == '0) stray_chk = stray_chk + 1;
  end

  task automatic clear_q();
    gq.delete(); rq.delete(); sq.delete(); eq.delete();
    stray_chk = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic hold_req(input logic [NREQ-1:0] r, input int edges);
    @(negedge clk);
    req = r;
    repeat (edges) @(posedge clk);
    @(negedge clk);
    req = '0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h want 00", rsp_data); end
    checks++; if (busy !== 1'b0 || eng_start !== 1'b0 || eng_data !== '0) begin
      errors++; $display("FAIL reset_ctrl got busy=%b start=%b eng_data=%b want 0/0/00000", busy, eng_start, eng_data);
    end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL idle_after_reset got busy=%b gnt=%b want 0/0000", busy, gnt); end
  endtask

  task automatic test_single();
    clear_q();
    set_data(0, 5'b10110);
    eq.push_back('{4'b0001, 6'h2D, 1'b0});
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    @(negedge clk);
    req = '0;
    repeat (8) @(negedge clk);
    checks++; if (gq.size() != 1 || rq.size() != 1 || sq.size() != 1) begin
      errors++; $display("FAIL single_counts got gnt=%0d rsp=%0d start=%0d want 1/1/1", gq.size(), rq.size(), sq.size());
    end else begin
      checks++; if (gq[0].v !== eq[0].g) begin errors++; $display("FAIL single_gnt got %b want %b", gq[0].v, eq[0].g); end
      checks++; if (sq[0] != gq[0].cyc + 2) begin errors++; $display("FAIL single_start_time got +%0d want +2", sq[0] - gq[0].cyc); end
      checks++; if (rq[0].cyc != gq[0].cyc + 4) begin errors++; $display("FAIL single_rsp_time got +%0d want +4", rq[0].cyc - gq[0].cyc); end
      checks++; if (rq[0].v !== eq[0].g) begin errors++; $display("FAIL single_rsp_valid got %b want %b", rq[0].v, eq[0].g); end
      checks++; if (rq[0].d !== eq[0].d) begin errors++; $display("FAIL single_rsp_data got %h want %h", rq[0].d, eq[0].d); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    checks++; if (rsp_data !== 6'h2D) begin errors++; $display("FAIL single_rsp_hold got %h want 2d", rsp_data); end
  endtask

  task automatic test_rotation();
    do_reset();
    clear_q();
    set_data(0, 5'b00000); set_data(1, 5'b11111);
    set_data(2, 5'b10101); set_data(3, 5'b01100);
    eq.push_back('{4'b0001, 6'h00, 1'b0});
    eq.push_back('{4'b0010, 6'h3F, 1'b0});
    eq.push_back('{4'b0100, 6'h2B, 1'b0});
    eq.push_back('{4'b1000, 6'h18, 1'b0});
    eq.push_back('{4'b0001, 6'h00, 1'b0});
    hold_req(4'b1111, 17);
    repeat (8) @(negedge clk);
    checks++; if (gq.size() != 5 || rq.size() != 5) begin
      errors++; $display("FAIL rot_counts got gnt=%0d rsp=%0d want 5/5", gq.size(), rq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (gq[i].v !== eq[i].g) begin errors++; $display("FAIL rot_gnt[%0d] got %b want %b", i, gq[i].v, eq[i].g); end
        checks++; if (rq[i].v !== eq[i].g) begin errors++; $display("FAIL rot_rsp_valid[%0d] got %b want %b", i, rq[i].v, eq[i].g); end
        checks++; if (rq[i].d !== eq[i].d) begin errors++; $display("FAIL rot_rsp_data[%0d] got %h want %h", i, rq[i].d, eq[i].d); end
        checks++; if (rq[i].cyc != gq[i].cyc + 4) begin errors++; $display("FAIL rot_rsp_time[%0d] got +%0d want +4", i, rq[i].cyc - gq[i].cyc); end
        if (i > 0) begin
          checks++; if (gq[i].cyc != gq[i-1].cyc + 4) begin errors++; $display("FAIL rot_spacing[%0d] got %0d want 4", i, gq[i].cyc - gq[i-1].cyc); end
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    clear_q();
    set_data(0, 5'b00001); set_data(2, 5'b00011);
    eq.push_back('{4'b0100, 6'h06, 1'b0});
    eq.push_back('{4'b0001, 6'h03, 1'b0});
    eq.push_back('{4'b0100, 6'h06, 1'b0});
    hold_req(4'b0100, 1);
    repeat (6) @(negedge clk);
    hold_req(4'b0101, 5);
    repeat (8) @(negedge clk);
    checks++; if (gq.size() != 3 || rq.size() != 3) begin
      errors++; $display("FAIL wrap_counts got gnt=%0d rsp=%0d want 3/3", gq.size(), rq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (gq[i].v !== eq[i].g) begin errors++; $display("FAIL wrap_gnt[%0d] got %b want %b", i, gq[i].v, eq[i].g); end
        checks++; if (rq[i].d !== eq[i].d) begin errors++; $display("FAIL wrap_rsp_data[%0d] got %h want %h", i, rq[i].d, eq[i].d); end
      end
    end
  endtask

  task automatic test_late_data();
    clear_q();
    set_data(1, 5'b11001);
    eq.push_back('{4'b0010, 6'h33, 1'b0});
    @(negedge clk);
    req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req = '0;
    set_data(1, 5'b00000);
    @(negedge clk);
    checks++; if (eng_data !== 5'b11001) begin errors++; $display("FAIL late_eng_data got %b want 11001", eng_data); end
    repeat (6) @(negedge clk);
    checks++; if (rq.size() != 1) begin
      errors++; $display("FAIL late_count got %0d want 1", rq.size());
    end else begin
      checks++; if (rq[0].v !== eq[0].g || rq[0].d !== eq[0].d) begin
        errors++; $display("FAIL late_rsp got %b/%h want %b/%h", rq[0].v, rq[0].d, eq[0].g, eq[0].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    set_data(0, 5'b01010);
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (eng_start !== 1'b1) begin errors++; $display("FAIL mid_in_start got %b want 1", eng_start); end
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++; if (gnt !== '0 || rsp_valid !== '0 || rsp_data !== '0 || busy !== 1'b0 || eng_start !== 1'b0 || eng_data !== '0) begin
      errors++; $display("FAIL mid_outputs got gnt=%b rv=%b rd=%h busy=%b st=%b ed=%b want all 0",
                         gnt, rsp_valid, rsp_data, busy, eng_start, eng_data);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL mid_dropped got %0d responses want 0", rq.size()); end
    clear_q();
    set_data(0, 5'b10000); set_data(3, 5'b11100);
    eq.push_back('{4'b0001, 6'h21, 1'b0});
    eq.push_back('{4'b1000, 6'h39, 1'b0});
    hold_req(4'b1001, 5);
    repeat (8) @(negedge clk);
    checks++; if (gq.size() != 2 || rq.size() != 2) begin
      errors++; $display("FAIL mid_after_counts got gnt=%0d rsp=%0d want 2/2", gq.size(), rq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (gq[i].v !== eq[i].g) begin errors++; $display("FAIL mid_after_gnt[%0d] got %b want %b", i, gq[i].v, eq[i].g); end
        checks++; if (rq[i].d !== eq[i].d) begin errors++; $display("FAIL mid_after_data[%0d] got %h want %h", i, rq[i].d, eq[i].d); end
      end
    end
  endtask

`ifdef PARITY_ARB_CHECK_EN
  task automatic test_check();
    clear_q();
    set_data(0, 5'b10110); set_data(2, 5'b00111);
    eq.push_back('{4'b0001, 6'h2C, 1'b1});
    eq.push_back('{4'b0100, 6'h0F, 1'b0});
    flip = 1'b1;
    hold_req(4'b0001, 1);
    repeat (6) @(negedge clk);
    flip = 1'b0;
    hold_req(4'b0100, 1);
    repeat (6) @(negedge clk);
    checks++; if (rq.size() != 2) begin
      errors++; $display("FAIL chk_count got %0d want 2", rq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (rq[i].chk !== eq[i].chk) begin errors++; $display("FAIL chk_err[%0d] got %b want %b", i, rq[i].chk, eq[i].chk); end
        checks++; if (rq[i].d !== eq[i].d) begin errors++; $display("FAIL chk_data[%0d] got %h want %h", i, rq[i].d, eq[i].d); end
      end
    end
    checks++; if (stray_chk != 0) begin errors++; $display("FAIL chk_stray got %0d want 0", stray_chk); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_late_data();
    test_reset_mid();
`ifdef PARITY_ARB_CHECK_EN
    test_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
